alarm_sequencer: RTL and testbench

Home-alarm controller that sequences the 1 Hz tick datapath (rate divider, 4-bit display counter, hex decoder). Moves through disarmed, exit-delay, armed, entry-delay and alarm states. Drives the divider's load and enable controls, so each timed phase starts on a full tick period. Exports the remaining-seconds count to HEX0 and a siren output to the board top level.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_sequencer_if.sv | 25 ++
 rtl/alarm_sequencer_phase_timer.sv | 39 +++
 rtl/alarm_sequencer.sv | 128 ++++++++++++
 tb/tb_alarm_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared state encodings and default phase lengths for the alarm sequencer.
package alarm_pkg;

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;

    typedef enum logic [2:0] {
        S_DISARMED = ST_DISARMED,
        S_EXIT     = ST_EXIT,
        S_ARMED    = ST_ARMED,
        S_ENTRY    = ST_ENTRY,
        S_ALARM    = ST_ALARM
    } state_t;

    localparam int unsigned DEF_EXIT_DELAY  = 10;
    localparam int unsigned DEF_ENTRY_DELAY = 5;
    localparam int unsigned DEF_ALARM_TIME  = 15;
    localparam int unsigned DEF_CNT_W       = 4;

    // Timed phases run the rate divider and own a countdown.
    function automatic logic is_timed(state_t s);
        return (s == S_EXIT) || (s == S_ENTRY) || (s == S_ALARM);
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Control/status bundle between the alarm sequencer and its surroundings.
interface alarm_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    logic             tick;
    logic             arm_req;
    logic             disarm_req;
    logic             sensor;
    logic             div_load;
    logic             div_enable;
    logic [CNT_W-1:0] countdown;
    logic [2:0]       state;
    logic             armed;
    logic             siren;

    modport master (
        output tick, arm_req, disarm_req, sensor,
        input  div_load, div_enable, countdown, state, armed, siren
    );

    modport slave (
        input  tick, arm_req, disarm_req, sensor,
        output div_load, div_enable, countdown, state, armed, siren
    );
endinterface

// File: rtl/alarm_sequencer_phase_timer.sv
// Per-phase countdown: load, decrement on accepted ticks, flag the final tick.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] value_o,
    output logic             done_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] value_q, value_d;

    // Next value: clear wins over load; the ==1 guard keeps the decrement from wrapping.
    always_comb begin
        value_d = value_q;
        if (clear_i)
            value_d = '0;
        else if (load_i)
            value_d = load_val_i;
        else if (tick_i && (value_q > ONE))
            value_d = value_q - ONE;
    end

    // Countdown register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value_o = value_q;
    assign done_o  = tick_i && (value_q == ONE);
endmodule

// File: rtl/alarm_sequencer.sv
// Home-alarm sequencer: steps through the arming/entry/alarm phases and drives
// the 1 Hz rate divider so every timed phase starts on a full tick period.
//
// state     | meaning
// DISARMED  | idle, divider stopped, waiting for arm_req
// EXIT      | exit delay running, sensor ignored
// ARMED     | watching sensor, divider stopped
// ENTRY     | entry delay running, disarm still possible
// ALARM     | siren on for ALARM_TIME ticks, re-armed or re-entered at timeout
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned EXIT_DELAY  = DEF_EXIT_DELAY,
    parameter int unsigned ENTRY_DELAY = DEF_ENTRY_DELAY,
    parameter int unsigned ALARM_TIME  = DEF_ALARM_TIME,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    alarm_sequencer_if.slave  bus
);
    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    if (EXIT_DELAY  < 1 || EXIT_DELAY  >= CNT_LIMIT ||
        ENTRY_DELAY < 1 || ENTRY_DELAY >= CNT_LIMIT ||
        ALARM_TIME  < 1 || ALARM_TIME  >= CNT_LIMIT) begin : g_bad_delay
        $error("alarm_sequencer: delay parameters must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] EXIT_VAL  = CNT_W'(EXIT_DELAY);
    localparam logic [CNT_W-1:0] ENTRY_VAL = CNT_W'(ENTRY_DELAY);
    localparam logic [CNT_W-1:0] ALARM_VAL = CNT_W'(ALARM_TIME);

    state_t           state_q, state_d;
    logic             div_load_q, div_enable_q, siren_q, armed_q;
    logic             load, clear, tick_acc, done;
    logic [CNT_W-1:0] load_val, count;

    // A tick landing in the load cycle belongs to the old divider period, so drop it.
    assign tick_acc = bus.tick && !div_load_q && is_timed(state_q);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (clear),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_i     (tick_acc),
        .value_o    (count),
        .done_o     (done)
    );

    // Next-state decode; disarm_req is checked first in every state.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            S_DISARMED: begin
                if (bus.arm_req && !bus.disarm_req) begin
                    state_d  = S_EXIT;
                    load     = 1'b1;
                    load_val = EXIT_VAL;
                end
            end
            S_EXIT: begin
                if (bus.disarm_req)
                    state_d = S_DISARMED;
                else if (done)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.disarm_req)
                    state_d = S_DISARMED;
                else if (bus.sensor) begin
                    state_d  = S_ENTRY;
                    load     = 1'b1;
                    load_val = ENTRY_VAL;
                end
            end
            S_ENTRY: begin
                if (bus.disarm_req)
                    state_d = S_DISARMED;
                else if (done) begin
                    state_d  = S_ALARM;
                    load     = 1'b1;
                    load_val = ALARM_VAL;
                end
            end
            S_ALARM: begin
                if (bus.disarm_req)
                    state_d = S_DISARMED;
                else if (done && bus.sensor) begin
                    state_d  = S_ALARM;
                    load     = 1'b1;
                    load_val = ALARM_VAL;
                end else if (done)
                    state_d = S_ARMED;
            end
            default: state_d = S_DISARMED;
        endcase
        clear = (state_d == S_DISARMED) || (state_d == S_ARMED);
    end

    // State and registered outputs, all derived from the next state so they change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_DISARMED;
            div_load_q   <= 1'b0;
            div_enable_q <= 1'b0;
            siren_q      <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_load_q   <= load;
            div_enable_q <= is_timed(state_d);
            siren_q      <= (state_d == S_ALARM);
            armed_q      <= (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
        end
    end

    assign bus.state      = state_q;
    assign bus.countdown  = count;
    assign bus.div_load   = div_load_q;
    assign bus.div_enable = div_enable_q;
    assign bus.siren      = siren_q;
    assign bus.armed      = armed_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with shortened phases (3/2/4 ticks).
module tb_alarm_sequencer;
    import alarm_pkg::*;

    localparam int unsigned CNT_W = 4;

    typedef struct {
        string      name;
        logic       tick, arm, dis, sen;
        logic [2:0] st;
        logic [3:0] cnt;
        logic       ld, en, arm_o, sir;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    alarm_sequencer_if #(.CNT_W(CNT_W)) bus ();

    alarm_sequencer #(
        .EXIT_DELAY  (3),
        .ENTRY_DELAY (2),
        .ALARM_TIME  (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] cnt,
                       input logic ld, input logic en, input logic ar, input logic sir);
        checks++;
        if ({bus.state, bus.countdown, bus.div_load, bus.div_enable, bus.armed, bus.siren} !==
            {st, cnt, ld, en, ar, sir}) begin
            errors++;
            $display("FAIL %s: got st=%0d cnt=%0d ld=%b en=%b armed=%b siren=%b, want st=%0d cnt=%0d ld=%b en=%b armed=%b siren=%b",
                     nm, bus.state, bus.countdown, bus.div_load, bus.div_enable, bus.armed, bus.siren,
                     st, cnt, ld, en, ar, sir);
        end
    endtask

    // Present inputs for one edge, then sample 1 ns after it.
    task automatic apply(input logic t, input logic a, input logic d, input logic s);
        bus.tick       = t;
        bus.arm_req    = a;
        bus.disarm_req = d;
        bus.sensor     = s;
        @(posedge clk);
        #1;
        bus.tick       = 1'b0;
        bus.arm_req    = 1'b0;
        bus.disarm_req = 1'b0;
    endtask

    task automatic add(input string nm, input logic t, input logic a, input logic d, input logic s,
                       input logic [2:0] st, input logic [3:0] cnt,
                       input logic ld, input logic en, input logic ar, input logic sir);
        vec_t v;
        v.name = nm; v.tick = t; v.arm = a; v.dis = d; v.sen = s;
        v.st = st; v.cnt = cnt; v.ld = ld; v.en = en; v.arm_o = ar; v.sir = sir;
        vecs.push_back(v);
    endtask

    initial begin
        int exp_cnt;

        //   name          t  a  d  s   state        cnt ld en ar si
        add("arm",        0, 1, 0, 0,  ST_EXIT,     3,  1, 1, 0, 0);
        add("exit_ldtick",1, 0, 0, 1,  ST_EXIT,     3,  0, 1, 0, 0);
        add("exit_idle",  0, 0, 0, 1,  ST_EXIT,     3,  0, 1, 0, 0);
        add("exit_t1",    1, 0, 0, 1,  ST_EXIT,     2,  0, 1, 0, 0);
        add("exit_idle2", 0, 0, 0, 1,  ST_EXIT,     2,  0, 1, 0, 0);
        add("exit_t2",    1, 0, 0, 1,  ST_EXIT,     1,  0, 1, 0, 0);
        add("exit_done",  1, 0, 0, 1,  ST_ARMED,    0,  0, 0, 1, 0);
        add("armed_arm",  0, 1, 0, 0,  ST_ARMED,    0,  0, 0, 1, 0);
        add("trip",       0, 0, 0, 1,  ST_ENTRY,    2,  1, 1, 1, 0);
        add("entry_ldtk", 1, 0, 0, 0,  ST_ENTRY,    2,  0, 1, 1, 0);
        add("entry_t1",   1, 0, 0, 0,  ST_ENTRY,    1,  0, 1, 1, 0);
        add("entry_done", 1, 0, 0, 0,  ST_ALARM,    4,  1, 1, 1, 1);
        add("alarm_idle", 0, 0, 0, 0,  ST_ALARM,    4,  0, 1, 1, 1);
        add("alarm_t1",   1, 0, 0, 0,  ST_ALARM,    3,  0, 1, 1, 1);
        add("alarm_t2",   1, 0, 0, 0,  ST_ALARM,    2,  0, 1, 1, 1);
        add("alarm_t3",   1, 0, 0, 0,  ST_ALARM,    1,  0, 1, 1, 1);
        add("alarm_rearm",1, 0, 0, 0,  ST_ARMED,    0,  0, 0, 1, 0);
        add("trip2",      0, 0, 0, 1,  ST_ENTRY,    2,  1, 1, 1, 0);
        add("entry2_hold",0, 0, 0, 1,  ST_ENTRY,    2,  0, 1, 1, 0);
        add("entry2_t1",  1, 0, 0, 1,  ST_ENTRY,    1,  0, 1, 1, 0);
        add("entry2_done",1, 0, 0, 1,  ST_ALARM,    4,  1, 1, 1, 1);
        add("al2_idle",   0, 0, 0, 1,  ST_ALARM,    4,  0, 1, 1, 1);
        add("al2_t1",     1, 0, 0, 1,  ST_ALARM,    3,  0, 1, 1, 1);
        add("al2_t2",     1, 0, 0, 1,  ST_ALARM,    2,  0, 1, 1, 1);
        add("al2_t3",     1, 0, 0, 1,  ST_ALARM,    1,  0, 1, 1, 1);
        add("al2_reenter",1, 0, 0, 1,  ST_ALARM,    4,  1, 1, 1, 1);
        add("al2_hold",   0, 0, 0, 1,  ST_ALARM,    4,  0, 1, 1, 1);
        add("al2_t4",     1, 0, 0, 0,  ST_ALARM,    3,  0, 1, 1, 1);
        add("al_disarm",  0, 0, 1, 0,  ST_DISARMED, 0,  0, 0, 0, 0);
        add("arm_and_dis",0, 1, 1, 0,  ST_DISARMED, 0,  0, 0, 0, 0);
        add("arm2",       0, 1, 0, 0,  ST_EXIT,     3,  1, 1, 0, 0);
        add("exit_disarm",0, 0, 1, 0,  ST_DISARMED, 0,  0, 0, 0, 0);
        add("arm3",       0, 1, 0, 0,  ST_EXIT,     3,  1, 1, 0, 0);
        add("arm3_idle",  0, 0, 0, 0,  ST_EXIT,     3,  0, 1, 0, 0);
        add("arm3_t1",    1, 0, 0, 0,  ST_EXIT,     2,  0, 1, 0, 0);
        add("arm3_t2",    1, 0, 0, 0,  ST_EXIT,     1,  0, 1, 0, 0);
        add("arm3_done",  1, 0, 0, 0,  ST_ARMED,    0,  0, 0, 1, 0);
        add("trip3",      0, 0, 0, 1,  ST_ENTRY,    2,  1, 1, 1, 0);
        add("trip3_idle", 0, 0, 0, 0,  ST_ENTRY,    2,  0, 1, 1, 0);
        add("trip3_t1",   1, 0, 0, 0,  ST_ENTRY,    1,  0, 1, 1, 0);
        add("dis_lasttk", 1, 0, 1, 0,  ST_DISARMED, 0,  0, 0, 0, 0);
        add("dis_tick",   1, 0, 0, 0,  ST_DISARMED, 0,  0, 0, 0, 0);

        // Reset held with arm_req asserted: nothing may leave DISARMED.
        reset_n        = 1'b0;
        bus.tick       = 1'b0;
        bus.arm_req    = 1'b1;
        bus.disarm_req = 1'b0;
        bus.sensor     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", ST_DISARMED, 0, 0, 0, 0, 0);
        bus.arm_req = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset", ST_DISARMED, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].tick, vecs[i].arm, vecs[i].dis, vecs[i].sen);
            chk(vecs[i].name, vecs[i].st, vecs[i].cnt, vecs[i].ld, vecs[i].en, vecs[i].arm_o, vecs[i].sir);
        end

        // Exit phase with ticks spaced 10 cycles apart and sensor held high throughout.
        apply(0, 1, 0, 1);
        chk("sp_arm", ST_EXIT, 3, 1, 1, 0, 0);
        exp_cnt = 3;
        for (int k = 0; k < 3; k++) begin
            repeat (9) apply(0, 0, 0, 1);
            chk("sp_gap", ST_EXIT, 4'(exp_cnt), 0, 1, 0, 0);
            apply(1, 0, 0, 1);
            exp_cnt--;
            if (k < 2)
                chk("sp_tick", ST_EXIT, 4'(exp_cnt), 0, 1, 0, 0);
            else
                chk("sp_armed", ST_ARMED, 0, 0, 0, 1, 0);
        end

        // Drive into ALARM, then pull reset between edges.
        apply(0, 0, 0, 1);
        chk("rs_trip", ST_ENTRY, 2, 1, 1, 1, 0);
        apply(1, 0, 0, 0);
        chk("rs_ldtick", ST_ENTRY, 2, 0, 1, 1, 0);
        apply(1, 0, 0, 0);
        chk("rs_t1", ST_ENTRY, 1, 0, 1, 1, 0);
        apply(1, 0, 0, 0);
        chk("rs_alarm", ST_ALARM, 4, 1, 1, 1, 1);
        apply(0, 0, 0, 0);
        chk("rs_hold", ST_ALARM, 4, 0, 1, 1, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", ST_DISARMED, 0, 0, 0, 0, 0);
        #10 reset_n = 1'b1;
        apply(1, 0, 0, 1);
        chk("after_reset", ST_DISARMED, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
